// File: rtl/ejercicio_4.sv
// Running-sum accumulator: adds i_ent into an OUT_W-bit register every edge.
// Overflow wraps by default; define EJERCICIO_4_SATURATE_EN to clamp instead.
module ejercicio_4 #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             i_rs,
    input  logic [IN_W-1:0]  i_ent,
    output logic [OUT_W-1:0] o_res
);

    localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int SUM_W = MAX_W + 1;

    logic [OUT_W-1:0] r_acc;
    logic [SUM_W-1:0] w_sum;
    logic [OUT_W-1:0] w_next;
    logic             w_ovf;

    assign w_sum = SUM_W'(r_acc) + SUM_W'(i_ent);
    assign w_ovf = |w_sum[SUM_W-1:OUT_W];

`ifdef EJERCICIO_4_SATURATE_EN
    assign w_next = w_ovf ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
`else
    // Discarding the carry bits gives sum mod 2^OUT_W.
    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf;
    assign w_next = w_sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge i_rs) begin
        if (!i_rs) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_next;
        end
    end

    assign o_res = r_acc;

endmodule

// File: tb/tb_ejercicio_4.sv
// Directed self-checking bench for the ejercicio_4 accumulator.
// Covers reset, accumulation, hold, overflow mode and release timing.
module tb_ejercicio_4;

    logic       clk = 1'b0;
    logic       i_rs = 1'b0;
    logic [9:0] i_ent = '0;
    logic [7:0] o_res;

    int n_cmp = 0;
    int n_err = 0;

    ejercicio_4 #(.IN_W(10), .OUT_W(8)) dut (
        .clk   (clk),
        .i_rs  (i_rs),
        .i_ent (i_ent),
        .o_res (o_res)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rs  = 1'b0;
        i_ent = 10'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (o_res !== 8'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got=%0d exp=0", i, o_res);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [9:0] ins [6];
        logic [7:0] exps [6];
        ins  = '{10'd4, 10'd4, 10'd4, 10'd6, 10'd6, 10'd10};
        exps = '{8'd4, 8'd8, 8'd12, 8'd18, 8'd24, 8'd34};
        i_rs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_ent = ins[i];
            tick();
            n_cmp++;
            if (o_res !== exps[i]) begin
                n_err++;
                $display("FAIL accum[%0d] got=%0d exp=%0d", i, o_res, exps[i]);
            end
        end
    endtask

    task automatic test_hold();
        i_ent = 10'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (o_res !== 8'd34) begin
                n_err++;
                $display("FAIL hold[%0d] got=%0d exp=34", i, o_res);
            end
        end
    endtask

    task automatic test_async_reset();
        #5 i_rs = 1'b0;
        tick();
        i_rs  = 1'b1;
        i_ent = 10'd4;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (o_res !== 8'd12) begin
            n_err++;
            $display("FAIL pre_async got=%0d exp=12", o_res);
        end
        #5 i_rs = 1'b0;
        #1;
        n_cmp++;
        if (o_res !== 8'd0) begin
            n_err++;
            $display("FAIL async_clear got=%0d exp=0", o_res);
        end
        tick();
        n_cmp++;
        if (o_res !== 8'd0) begin
            n_err++;
            $display("FAIL async_held got=%0d exp=0", o_res);
        end
    endtask

    task automatic test_overflow();
        i_rs  = 1'b1;
        i_ent = 10'd250;
        tick();
        n_cmp++;
        if (o_res !== 8'd250) begin
            n_err++;
            $display("FAIL ovf_load got=%0d exp=250", o_res);
        end
        i_ent = 10'd10;
        tick();
`ifdef EJERCICIO_4_SATURATE_EN
        n_cmp++;
        if (o_res !== 8'd255) begin
            n_err++;
            $display("FAIL sat_250p10 got=%0d exp=255", o_res);
        end
        i_ent = 10'd4;
        tick();
        n_cmp++;
        if (o_res !== 8'd255) begin
            n_err++;
            $display("FAIL sat_255p4 got=%0d exp=255", o_res);
        end
`else
        n_cmp++;
        if (o_res !== 8'd4) begin
            n_err++;
            $display("FAIL wrap_250p10 got=%0d exp=4", o_res);
        end
`endif
        #5 i_rs = 1'b0;
        tick();
        i_rs  = 1'b1;
        i_ent = 10'd1023;
        tick();
        n_cmp++;
        if (o_res !== 8'd255) begin
            n_err++;
            $display("FAIL big_in got=%0d exp=255", o_res);
        end
`ifdef EJERCICIO_4_SATURATE_EN
        #5 i_rs = 1'b0;
        #1;
        n_cmp++;
        if (o_res !== 8'd0) begin
            n_err++;
            $display("FAIL sat_rst got=%0d exp=0", o_res);
        end
        tick();
        i_rs  = 1'b1;
        i_ent = 10'd4;
        tick();
        n_cmp++;
        if (o_res !== 8'd4) begin
            n_err++;
            $display("FAIL sat_restart got=%0d exp=4", o_res);
        end
`else
        i_ent = 10'd2;
        tick();
        n_cmp++;
        if (o_res !== 8'd1) begin
            n_err++;
            $display("FAIL wrap_255p2 got=%0d exp=1", o_res);
        end
`endif
    endtask

    task automatic test_release_timing();
        #5 i_rs = 1'b0;
        i_ent = 10'd7;
        @(posedge clk);
        #18 i_rs = 1'b1;
        tick();
        n_cmp++;
        if (o_res !== 8'd7) begin
            n_err++;
            $display("FAIL early_release got=%0d exp=7", o_res);
        end
        #5 i_rs = 1'b0;
        #1;
        n_cmp++;
        if (o_res !== 8'd0) begin
            n_err++;
            $display("FAIL rel_setup got=%0d exp=0", o_res);
        end
        // Release lands on the edge itself; the DUT must still see reset.
        @(posedge clk);
        i_rs <= 1'b1;
        #1;
        n_cmp++;
        if (o_res !== 8'd0) begin
            n_err++;
            $display("FAIL coincident_edge got=%0d exp=0", o_res);
        end
        tick();
        n_cmp++;
        if (o_res !== 8'd7) begin
            n_err++;
            $display("FAIL coincident_next got=%0d exp=7", o_res);
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_hold();
        test_async_reset();
        test_overflow();
        test_release_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ejercicio_4.md
Name: ejercicio_4

Overview:
- Clocked running-sum accumulator for the sequential-exercise set.
- Adds the input word `i_ent` into an internal accumulator on every rising clock edge.
- Presents the accumulated value on `o_res`.
- Standalone leaf block; the accumulator is cleared only by reset.

Parameters:
- IN_W, 10, width of input word `i_ent`.
- OUT_W, 8, width of accumulator and output `o_res`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- i_rs  input  1  reset; asynchronous, active-low (0 = reset asserted).
- i_ent  input  IN_W (10)  unsigned value added each cycle.
- o_res  output  OUT_W (8)  current accumulator value, unsigned.

Behaviour:
- State: one OUT_W-bit accumulator register `acc`. `o_res` is driven directly from `acc`, with no combinational path from `i_ent`.
- Reset: `i_rs`=0 forces `acc`=0 immediately, without waiting for a clock edge. `acc` is held at 0 for as long as `i_rs`=0, and the `clk` edges in that interval are ignored.
- Reset release: first accumulation happens on the first rising edge with `i_rs`=1. Release coincident with an edge is treated as still in reset for that edge.
- Normal operation, each rising edge with `i_rs`=1: `acc` <= f(`acc` + `i_ent`).
  - The sum is formed at max(IN_W, OUT_W)+1 bits (11 bits by default), zero-extended, unsigned.
- Latency: a value on `i_ent` meeting setup before edge N appears in `o_res` after edge N. That is one cycle; `o_res` changes only just after rising edges or on reset assertion.
- `i_ent`=0 holds `acc` unchanged.
- Overflow handling, f():
  - Wrap mode, the default: f = sum mod 2^OUT_W, keeping the low OUT_W bits. Wrap-around is silent, e.g. 250 + 10 -> 4.
  - Saturate mode (see Optional Feature).
- `i_ent` wider than `o_res`: a single input above 255 is legal.
  - Wrap mode: its low bits add in mod 256.
  - Saturate mode: result is 255.
- Reset mid-operation: asynchronous clear to 0 regardless of pending sum. Accumulation restarts from 0 after release.
- No X propagation after reset: all state has a defined reset value.

Optional Feature:
- Macro: EJERCICIO_4_SATURATE_EN.
- Defined: f = min(sum, 2^OUT_W - 1).
  - `acc` clamps at 255 and stays there while inputs are nonzero.
  - Only reset returns it to 0, e.g. 250 + 10 -> 255, and 255 + 4 -> 255.
- Undefined: wrap mode as above. Identical to defined mode whenever the sum stays at or below 255.

Test Plan (clk period 20 ns; all inputs change away from rising edges):
- Reset: `i_rs`=0 with `i_ent`=4 for 5 edges -> `o_res`=0 throughout. Assert `i_rs`=0 mid-cycle while `acc`=12 -> `o_res`=0 before the next edge.
- Accumulate: release `i_rs`=1, `i_ent`=4 for 3 edges -> `o_res` 4, 8, 12. Then `i_ent`=6 for 2 edges -> 18, 24. Then `i_ent`=10 for 1 edge -> 34.
- Hold: `i_ent`=0 for 10 edges from 34 -> `o_res` stays 34.
- Wrap (macro undefined): from 250, `i_ent`=10 -> 4. From 0, `i_ent`=1023 -> 255. Then `i_ent`=2 -> 1.
- Saturate (macro defined): from 250, `i_ent`=10 -> 255. Then `i_ent`=4 -> 255. From 0, `i_ent`=1023 -> 255. Then pulse `i_rs`=0 -> 0, and `i_ent`=4 after release -> 4.
- Reset release timing: deassert `i_rs` 2 ns before an edge with `i_ent`=7 -> `o_res`=7 after that edge. Deassert coincident with the edge -> `o_res`=0 after that edge, 7 after the next.
